// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous RAM port between the
// CPU controller (master 0) and a loader/DMA master (master 1), with WAIT extra cycles per access.
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int WAIT   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [1:0]        m0_cmd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic [1:0]        m1_cmd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_done,
  output logic              m1_done,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [3:0] WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic        v0_s, v1_s;

  // Requests with MNONE or the reserved encoding are never eligible.
  assign v0_s = m0_req & ((m0_cmd == MREAD) | (m0_cmd == MWRITE));
  assign v1_s = m1_req & ((m1_cmd == MREAD) | (m1_cmd == MWRITE));

  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= 4'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_done   = 1'b0;
    m1_done   = 1'b0;
    mem_cmd   = MNONE;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        // On a tie, the master that was not granted last wins.
        if (v0_s && (!v1_s || last_q)) begin
          state_d = G0;
          last_d  = 1'b0;
          cnt_d   = WAIT_C;
        end else if (v1_s) begin
          state_d = G1;
          last_d  = 1'b1;
          cnt_d   = WAIT_C;
        end else begin
          state_d = IDLE;
        end
      end
      G0: begin
        m0_gnt    = 1'b1;
        mem_cmd   = m0_cmd;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          m0_done   = 1'b1;
          rvalid0_d = (m0_cmd == MREAD);
          // Only the other master is considered, so the finisher cannot be re-granted at once.
          if (v1_s) begin
            state_d = G1;
            last_d  = 1'b1;
            cnt_d   = WAIT_C;
          end else begin
            state_d = IDLE;
          end
        end
      end
      G1: begin
        m1_gnt    = 1'b1;
        mem_cmd   = m1_cmd;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          m1_done   = 1'b1;
          rvalid1_d = (m1_cmd == MREAD);
          if (v0_s) begin
            state_d = G0;
            last_d  = 1'b0;
            cnt_d   = WAIT_C;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single synchronous RAM port (`mem_cmd`/`mem_addr`) between the CPU controller (master 0) and a second bus master (master 1, loader/DMA). It sits between the masters and the RAM and sequences each access with a grant/done handshake and a read-valid strobe. Arbitration is round-robin on contention. A programmable number of wait states models slower memory.

## Interface
- `ADDR_W`, 9, address width
- `DATA_W`, 16, data width
- `WAIT`, 0, extra cycles each access holds the RAM port (0..15)

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: reset is asynchronous and active-high.
- `m0_req`, `m1_req` in 1: request; held with cmd/addr/wdata stable until `done`.
- `m0_cmd`, `m1_cmd` in 2: `MNONE`=00, `MREAD`=01, `MWRITE`=10; 11 is illegal.
- `m0_addr`, `m1_addr` in ADDR_W: access address.
- `m0_wdata`, `m1_wdata` in DATA_W: write data.
- `m0_gnt`, `m1_gnt` out 1: master owns the RAM port this cycle.
- `m0_done`, `m1_done` out 1: one-cycle pulse on the last grant cycle.
- `m0_rvalid`, `m1_rvalid` out 1: one-cycle pulse; read data valid.
- `m0_rdata`, `m1_rdata` out DATA_W: equal to `mem_rdata` at all times; qualified by rvalid.
- `mem_cmd` out 2, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: RAM port.
- `mem_rdata` in DATA_W: RAM read data, valid the cycle after the address is presented.

## Operation
- A request is *valid* when `req`=1 and `cmd` is 01 or 10. `req` with cmd 00 or 11 is ignored and never granted.
- States: `IDLE`, `G0`, `G1`. Registers: `last` (the last granted master) and a 4-bit wait counter `cnt`.
- In `IDLE`:
  - Only m0 valid: go to `G0`. Only m1 valid: go to `G1`.
  - Both valid: grant the master that is not `last`.
  - Neither valid: stay in `IDLE`.
- Entering `Gx`: set `cnt`=WAIT and `last`=x.
- In `Gx`:
  - `mx_gnt`=1.
  - `mem_cmd`/`mem_addr`/`mem_wdata` come from master x.
  - When `cnt`≠0, decrement `cnt`.
  - When `cnt`=0, `mx_done`=1 and the access is complete.
- On completion, the other master, if valid, is granted directly (`G0` to `G1` or `G1` to `G0`, back-to-back). Otherwise go to `IDLE`.
- The just-completed master is never eligible in the cycle right after its done. This covers its `req` still being high during the edge at which done is sampled.
- Outside `G0`/`G1`: `mem_cmd`=`MNONE`, `mem_addr`=0, `mem_wdata`=0, and all gnt/done are 0.
- When a completed access was a `MREAD`, `mx_rvalid`=1 in the cycle after `done`. That cycle may overlap a new grant to the other master.
- A write asserts `MWRITE` for all WAIT+1 grant cycles. The RAM may commit on any of them, but the address and data are stable.
- A master changing cmd or addr while granted is a protocol violation; behaviour is unspecified. The bench checks stability with assertions.

## Timing
- Reset values: state=`IDLE`, `last`=1 (so m0 wins the first tie), `cnt`=0, all gnt/done/rvalid=0, `mem_cmd`=`MNONE`.
- Grant latency: `gnt` rises on the first edge after a valid request is seen in `IDLE`. That is 1 cycle.
- Each access occupies the port for WAIT+1 cycles.
- Read data: `rvalid` comes 1 cycle after `done`. Request-to-data with WAIT=0 is 3 cycles.
- Peak throughput with alternating masters: one access per WAIT+1 cycles. A single master gets at most one access per WAIT+2 cycles.
- Simultaneous requests in `IDLE` follow the round-robin rule via `last`. A new request arriving during a grant waits for completion.
- Reset asserted mid-access: everything returns to reset values asynchronously. A pending `rvalid` is dropped, and `mem_cmd` goes to `MNONE` immediately.

## Test plan
- Single read, WAIT=0: m0 reads addr 0x005 while the RAM holds 0xABCD. Expect `m0_gnt`/`m0_done` in cycle 2, `mem_cmd`=01, `mem_addr`=0x005; then `m0_rvalid`=1 with `m0_rdata`=0xABCD in cycle 3.
- Contention from reset: both masters request in the same cycle, m0 writing 0x1234 to 0x010 and m1 reading 0x010. Expect m0 granted first, then m1 granted back-to-back, and `m1_rdata`=0x1234 on `m1_rvalid`.
- Round-robin fairness: both masters hold valid requests for 8 accesses. Expect grants alternating m0, m1, m0, … with no master granted twice in a row.
- WAIT=3: an m1 write of 0x00FF to 0x1F0. Expect `m1_gnt` high for 4 cycles with `mem_cmd`=10 stable, `m1_done` only in the 4th cycle, and `m1_rvalid` never asserted.
- Illegal and idle commands: `m0_req`=1 with cmd 11, and `m1_req`=1 with cmd 00. Expect no grant, state stays `IDLE`, and `mem_cmd`=00 throughout.
- Reset mid-read: assert `reset` during an m0 read grant with WAIT=2. Expect all outputs 0 and `mem_cmd`=00 immediately, and no `rvalid` after release.
